// File: rtl/hold_bus_arbiter.sv
// Round-robin HOLD/HLDA arbiter sharing the 8088 local bus between the CPU and NREQ alternate masters.
// Tenures are bounded by MAX_HOLD_CYCLES and separated by at least CPU_GAP processor-owned cycles.
module hold_bus_arbiter #(
  parameter int unsigned NREQ            = 4,
  parameter int unsigned MAX_HOLD_CYCLES = 64,
  parameter int unsigned CPU_GAP         = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          REQ,
  input  logic [NREQ-1:0]          DONE,
  input  logic                     HLDA,
  output logic                     HOLD,
  output logic [NREQ-1:0]          GNT,
  output logic [$clog2(NREQ)-1:0]  OWNER,
  output logic                     BUSY,
  output logic                     TIMEOUT
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(MAX_HOLD_CYCLES + 1);
  localparam int unsigned GW = (CPU_GAP == 0) ? 1 : $clog2(CPU_GAP + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HLDA,
    GRANT,
    RELEASE,
    GAP
  } state_t;

  state_t          r_state;
  logic            r_hold;
  logic [NREQ-1:0] r_gnt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_ptr;
  logic            r_busy;
  logic            r_timeout;
  logic [CW-1:0]   r_cnt;
  logic [GW-1:0]   r_gap;

  logic [OW-1:0]   w_winner;
  logic            w_found;
  logic [OW-1:0]   w_ptr_next;
  logic            w_own_done;
  logic            w_own_drop;
  logic            w_limit;

  // First requester at or above the pointer, wrapping at NREQ
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!w_found && REQ[(int'(r_ptr) + i) % int'(NREQ)]) begin
        w_found  = 1'b1;
        w_winner = OW'((int'(r_ptr) + i) % int'(NREQ));
      end
    end
  end

  assign w_ptr_next = (w_winner == OW'(NREQ - 1)) ? '0 : w_winner + OW'(1);
  assign w_own_done = DONE[r_owner];
  assign w_own_drop = !REQ[r_owner];
  assign w_limit    = (r_cnt == CW'(MAX_HOLD_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_hold    <= 1'b0;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_gap     <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          // A stale HLDA from before reset must clear before a new HOLD
          if (w_found && !HLDA) begin
            r_owner <= w_winner;
            r_ptr   <= w_ptr_next;
            r_hold  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= WAIT_HLDA;
          end
        end
        WAIT_HLDA: begin
          if (HLDA) begin
            r_gnt   <= NREQ'(1) << r_owner;
            r_cnt   <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (!HLDA) begin
            r_gnt   <= '0;
            r_hold  <= 1'b0;
            r_gap   <= '0;
            r_state <= GAP;
          end else if (w_own_done || w_own_drop || w_limit) begin
            r_gnt     <= '0;
            r_hold    <= 1'b0;
            r_timeout <= w_limit && !w_own_done && !w_own_drop;
            r_state   <= RELEASE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (!HLDA) begin
            r_gap   <= '0;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (CPU_GAP == 0 || (r_gap + GW'(1)) == GW'(CPU_GAP)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: begin
          r_gnt   <= '0;
          r_hold  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign HOLD    = r_hold;
  assign GNT     = r_gnt;
  assign OWNER   = r_owner;
  assign BUSY    = r_busy;
  assign TIMEOUT = r_timeout;

endmodule
